// File: rtl/request_queue_pkg.sv
// Shared types and defaults for the request queue.
package request_queue_pkg;

    localparam int ADDRESS_WIDTH       = 32;
    localparam int QUEUE_DEPTH_DEFAULT = 16;
    localparam int AGE_WIDTH_DEFAULT   = 12;

    typedef enum logic [1:0] {
        NOP     = 2'd0,
        READ    = 2'd1,
        WRITE   = 2'd2,
        REFRESH = 2'd3
    } parsed_op_t;

    typedef enum logic [1:0] {
        Q_EMPTY  = 2'd0,
        Q_ACTIVE = 2'd1,
        Q_FULL   = 2'd2
    } queue_states_t;

    typedef struct packed {
        parsed_op_t                   op;
        logic [ADDRESS_WIDTH-1:0]     addr;
        logic [AGE_WIDTH_DEFAULT-1:0] age;
    } queue_entry_t;

endpackage

// File: rtl/request_queue_if.sv
// Parser/scheduler side of the request queue; master drives requests and pops.
interface request_queue_if
    import request_queue_pkg::*;
#(
    parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEFAULT,
    parameter int AGE_WIDTH   = AGE_WIDTH_DEFAULT
);
    logic                           op_ready_s;
    parsed_op_t                     opcode;
    logic [ADDRESS_WIDTH-1:0]       address;
    logic                           pop;
    logic                           queue_full;
    logic                           out_valid;
    parsed_op_t                     out_opcode;
    logic [ADDRESS_WIDTH-1:0]       out_address;
    logic [AGE_WIDTH-1:0]           out_age;
    logic [$clog2(QUEUE_DEPTH):0]   count;
    logic                           overflow_err;
    queue_states_t                  state;

    modport master (
        output op_ready_s, opcode, address, pop,
        input  queue_full, out_valid, out_opcode, out_address, out_age,
               count, overflow_err, state
    );

    modport slave (
        input  op_ready_s, opcode, address, pop,
        output queue_full, out_valid, out_opcode, out_address, out_age,
               count, overflow_err, state
    );
endinterface

// File: rtl/request_queue_age_counter.sv
// Per-entry saturating age counter; load clears it for a freshly written entry.
module age_counter #(
    parameter int AGE_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 en,
    output logic [AGE_WIDTH-1:0] age
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            age <= '0;
        else if (load)
            age <= '0;
        else if (en && (age != '1))
            age <= age + AGE_WIDTH'(1);
    end
endmodule

// File: rtl/request_queue.sv
// In-order circular request buffer between trace parser and DRAM scheduler,
// with show-ahead head outputs and per-entry age tracking.
module request_queue
    import request_queue_pkg::*;
#(
    parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEFAULT,
    parameter int AGE_WIDTH   = AGE_WIDTH_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    request_queue_if.slave  q
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

    logic [PW-1:0]                              head, tail;
    logic [CW-1:0]                              count_r, count_nxt;
    parsed_op_t                                 op_mem [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0][ADDRESS_WIDTH-1:0]  addr_mem;
    logic [QUEUE_DEPTH-1:0][AGE_WIDTH-1:0]      ages;
    logic [QUEUE_DEPTH-1:0]                     occ, load;
    logic                                       push_req, push_ok, do_pop, ovf_r;
    queue_states_t                              state_r, state_nxt;

    // A full queue still accepts a push when the head retires in the same cycle.
    assign push_req  = q.op_ready_s && (q.opcode != NOP);
    assign do_pop    = q.pop && (count_r != '0);
    assign push_ok   = push_req && ((count_r != DEPTH_C) || do_pop);
    assign count_nxt = count_r + {{(CW-1){1'b0}}, push_ok} - {{(CW-1){1'b0}}, do_pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= '0;
            tail    <= '0;
            count_r <= '0;
            ovf_r   <= 1'b0;
        end else begin
            if (push_ok) tail <= tail + PW'(1);
            if (do_pop)  head <= head + PW'(1);
            count_r <= count_nxt;
            ovf_r   <= push_req && !push_ok;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                op_mem[i]   <= NOP;
                addr_mem[i] <= '0;
            end
        end else if (push_ok) begin
            op_mem[tail]   <= q.opcode;
            addr_mem[tail] <= q.address;
        end
    end

    // Push wins over pop on the same slot: that only happens when full and the
    // freed head slot is immediately refilled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= '0;
        end else begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (push_ok && (tail == PW'(i)))
                    occ[i] <= 1'b1;
                else if (do_pop && (head == PW'(i)))
                    occ[i] <= 1'b0;
            end
        end
    end

    for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_age
        assign load[gi] = push_ok && (tail == PW'(gi));
        age_counter #(.AGE_WIDTH(AGE_WIDTH)) u_age (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[gi]),
            .en    (occ[gi]),
            .age   (ages[gi])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= Q_EMPTY;
        else        state_r <= state_nxt;
    end

    always_comb begin
        state_nxt = state_r;
        case (state_r)
            Q_EMPTY:  if (push_ok) state_nxt = Q_ACTIVE;
            Q_ACTIVE: begin
                if (count_nxt == DEPTH_C)  state_nxt = Q_FULL;
                else if (count_nxt == '0)  state_nxt = Q_EMPTY;
            end
            Q_FULL:   if (do_pop && !push_ok) state_nxt = Q_ACTIVE;
            default:  state_nxt = Q_EMPTY;
        endcase
    end

    always_comb begin
        q.queue_full   = (state_r == Q_FULL);
        q.state        = state_r;
        q.count        = count_r;
        q.overflow_err = ovf_r;
        q.out_valid    = (count_r != '0);
        q.out_opcode   = NOP;
        q.out_address  = '0;
        q.out_age      = '0;
        if (count_r != '0) begin
            q.out_opcode  = op_mem[head];
            q.out_address = addr_mem[head];
            q.out_age     = ages[head];
        end
    end
endmodule

// File: tb/tb_request_queue.sv
// Directed checks of request_queue: ordering, back-pressure, ageing, reset.
module tb_request_queue;
    import request_queue_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    request_queue_if #(.QUEUE_DEPTH(16), .AGE_WIDTH(3)) bus ();

    request_queue #(.QUEUE_DEPTH(16), .AGE_WIDTH(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (bus)
    );

    task automatic drive(input logic rdy, input parsed_op_t op, input logic [31:0] a, input logic p);
        bus.op_ready_s = rdy;
        bus.opcode     = op;
        bus.address    = a;
        bus.pop        = p;
        @(posedge clk);
        #1;
        bus.op_ready_s = 1'b0;
        bus.opcode     = NOP;
        bus.address    = '0;
        bus.pop        = 1'b0;
    endtask

    task automatic test_reset;
        bus.op_ready_s = 1'b0; bus.opcode = NOP; bus.address = '0; bus.pop = 1'b0;
        rst_n = 1'b0;
        #12;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.count !== 5'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        n_cmp++; if (bus.state !== Q_EMPTY) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", bus.state, Q_EMPTY); end
        n_cmp++; if (bus.queue_full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", bus.queue_full); end
        n_cmp++; if (bus.overflow_err !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", bus.overflow_err); end
        n_cmp++; if ({bus.out_opcode, bus.out_address, bus.out_age} !== {NOP, 32'h0, 3'd0})
            begin n_bad++; $display("FAIL reset_head: got %0d/%h/%0d want 0/0/0", bus.out_opcode, bus.out_address, bus.out_age); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single;
        drive(1'b1, READ, 32'h1F40, 1'b0);
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.out_opcode !== READ) begin n_bad++; $display("FAIL single_op: got %0d want %0d", bus.out_opcode, READ); end
        n_cmp++; if (bus.out_address !== 32'h1F40) begin n_bad++; $display("FAIL single_addr: got %h want 1f40", bus.out_address); end
        n_cmp++; if (bus.out_age !== 3'd0) begin n_bad++; $display("FAIL single_age0: got %0d want 0", bus.out_age); end
        n_cmp++; if (bus.count !== 5'd1) begin n_bad++; $display("FAIL single_count: got %0d want 1", bus.count); end
        n_cmp++; if (bus.state !== Q_ACTIVE) begin n_bad++; $display("FAIL single_state: got %0d want %0d", bus.state, Q_ACTIVE); end
        for (int i = 0; i < 5; i++) drive(1'b0, NOP, 32'h0, 1'b0);
        n_cmp++; if (bus.out_age !== 3'd5) begin n_bad++; $display("FAIL single_age5: got %0d want 5", bus.out_age); end
        drive(1'b0, NOP, 32'h0, 1'b1);
        n_cmp++; if ({bus.out_valid, bus.count} !== {1'b0, 5'd0}) begin n_bad++; $display("FAIL single_pop: got valid %b count %0d want 0/0", bus.out_valid, bus.count); end
    endtask

    task automatic test_full_overflow;
        for (int i = 0; i < 16; i++) drive(1'b1, WRITE, 32'(i), 1'b0);
        n_cmp++; if (bus.queue_full !== 1'b1) begin n_bad++; $display("FAIL full_flag: got %b want 1", bus.queue_full); end
        n_cmp++; if (bus.state !== Q_FULL) begin n_bad++; $display("FAIL full_state: got %0d want %0d", bus.state, Q_FULL); end
        n_cmp++; if (bus.count !== 5'd16) begin n_bad++; $display("FAIL full_count: got %0d want 16", bus.count); end
        n_cmp++; if (bus.out_address !== 32'h0) begin n_bad++; $display("FAIL full_head: got %h want 0", bus.out_address); end
        drive(1'b1, WRITE, 32'h10, 1'b0);
        n_cmp++; if (bus.overflow_err !== 1'b1) begin n_bad++; $display("FAIL ovf_pulse: got %b want 1", bus.overflow_err); end
        n_cmp++; if (bus.count !== 5'd16) begin n_bad++; $display("FAIL ovf_count: got %0d want 16", bus.count); end
        drive(1'b0, NOP, 32'h0, 1'b0);
        n_cmp++; if (bus.overflow_err !== 1'b0) begin n_bad++; $display("FAIL ovf_one_cycle: got %b want 0", bus.overflow_err); end
        drive(1'b1, READ, 32'h20, 1'b1);
        n_cmp++; if (bus.count !== 5'd16) begin n_bad++; $display("FAIL pushpop_full_count: got %0d want 16", bus.count); end
        n_cmp++; if (bus.overflow_err !== 1'b0) begin n_bad++; $display("FAIL pushpop_full_ovf: got %b want 0", bus.overflow_err); end
        n_cmp++; if (bus.state !== Q_FULL) begin n_bad++; $display("FAIL pushpop_full_state: got %0d want %0d", bus.state, Q_FULL); end
        for (int k = 0; k < 16; k++) begin
            logic [31:0] exp_a;
            exp_a = (k < 15) ? 32'(k + 1) : 32'h20;
            n_cmp++; if ({bus.out_valid, bus.out_address} !== {1'b1, exp_a})
                begin n_bad++; $display("FAIL drain_%0d: got valid %b addr %h want 1/%h", k, bus.out_valid, bus.out_address, exp_a); end
            if (k == 15) begin
                n_cmp++; if (bus.out_opcode !== READ) begin n_bad++; $display("FAIL drain_tail_op: got %0d want %0d", bus.out_opcode, READ); end
            end
            drive(1'b0, NOP, 32'h0, 1'b1);
            if (k == 0) begin
                n_cmp++; if (bus.state !== Q_ACTIVE) begin n_bad++; $display("FAIL full_to_active: got %0d want %0d", bus.state, Q_ACTIVE); end
            end
        end
        n_cmp++; if ({bus.out_valid, bus.out_opcode, bus.out_address} !== {1'b0, NOP, 32'h0})
            begin n_bad++; $display("FAIL drain_empty: got valid %b op %0d addr %h want 0/0/0", bus.out_valid, bus.out_opcode, bus.out_address); end
        n_cmp++; if ({bus.state, bus.count, bus.queue_full} !== {Q_EMPTY, 5'd0, 1'b0})
            begin n_bad++; $display("FAIL drain_state: got state %0d count %0d full %b want 0/0/0", bus.state, bus.count, bus.queue_full); end
    endtask

    task automatic test_empty_edges;
        drive(1'b0, NOP, 32'h0, 1'b1);
        n_cmp++; if ({bus.count, bus.out_valid, bus.overflow_err} !== {5'd0, 1'b0, 1'b0})
            begin n_bad++; $display("FAIL empty_pop: got count %0d valid %b ovf %b want 0/0/0", bus.count, bus.out_valid, bus.overflow_err); end
        drive(1'b1, NOP, 32'h77, 1'b0);
        n_cmp++; if (bus.count !== 5'd0) begin n_bad++; $display("FAIL nop_ignored: got %0d want 0", bus.count); end
        drive(1'b1, WRITE, 32'h55, 1'b1);
        n_cmp++; if ({bus.count, bus.out_address} !== {5'd1, 32'h55})
            begin n_bad++; $display("FAIL empty_pushpop: got count %0d addr %h want 1/55", bus.count, bus.out_address); end
        drive(1'b0, NOP, 32'h0, 1'b1);
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 3; i++) drive(1'b1, READ, 32'h100 + 32'(i), 1'b0);
        for (int i = 0; i < 40; i++) begin
            n_cmp++; if ({bus.count, bus.out_address} !== {5'd3, 32'h100 + 32'(i)})
                begin n_bad++; $display("FAIL wrap_%0d: got count %0d addr %h want 3/%h", i, bus.count, bus.out_address, 32'h100 + 32'(i)); end
            drive(1'b1, WRITE, 32'h103 + 32'(i), 1'b1);
        end
        for (int i = 40; i < 43; i++) begin
            n_cmp++; if (bus.out_address !== 32'h100 + 32'(i))
                begin n_bad++; $display("FAIL wrap_drain_%0d: got %h want %h", i, bus.out_address, 32'h100 + 32'(i)); end
            drive(1'b0, NOP, 32'h0, 1'b1);
        end
        n_cmp++; if (bus.count !== 5'd0) begin n_bad++; $display("FAIL wrap_empty: got %0d want 0", bus.count); end
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 7; i++) drive(1'b1, READ, 32'hA0 + 32'(i), 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b0, NOP, 32'h0, 1'b0);
        n_cmp++; if ({bus.count, bus.out_age} !== {5'd7, 3'd7})
            begin n_bad++; $display("FAIL age_sat: got count %0d age %0d want 7/7", bus.count, bus.out_age); end
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus.out_valid, bus.count, bus.out_age, bus.out_address, bus.state} !== {1'b0, 5'd0, 3'd0, 32'h0, Q_EMPTY})
            begin n_bad++; $display("FAIL async_rst: got valid %b count %0d age %0d addr %h state %0d want all 0", bus.out_valid, bus.count, bus.out_age, bus.out_address, bus.state); end
        #2 rst_n = 1'b1;
        drive(1'b0, NOP, 32'h0, 1'b0);
        n_cmp++; if ({bus.count, bus.out_valid} !== {5'd0, 1'b0})
            begin n_bad++; $display("FAIL post_rst: got count %0d valid %b want 0/0", bus.count, bus.out_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_overflow();
        test_empty_edges();
        test_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
